// File: rtl/uart_rx_fifo_if.sv
// CPU-side bundle of the UART receiver: FIFO head, status flags and pop strobe.
// slave is the UART end, master is the CPU input-port end.
interface uart_rx_fifo_if;
    logic [7:0] rx_data_out;
    logic       rx_data_present;
    logic       read_rx_data_ack;
    logic       rx_buffer_full;
    logic       rx_overrun;
    logic       rx_framing_error;

    modport master (
        input  rx_data_out,
        input  rx_data_present,
        input  rx_buffer_full,
        input  rx_overrun,
        input  rx_framing_error,
        output read_rx_data_ack
    );

    modport slave (
        output rx_data_out,
        output rx_data_present,
        output rx_buffer_full,
        output rx_overrun,
        output rx_framing_error,
        input  read_rx_data_ack
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x oversampled 8N1 UART receiver feeding a first-word-fall-through FIFO.
// A stop bit sampled low enters BREAK until the line idles high again.
module uart_rx_fifo #(
    parameter int OVERSAMPLE_DIV = 651,
    parameter int FIFO_AW        = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rs232_rx,
    uart_rx_fifo_if.slave  rx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DW    = $clog2(OVERSAMPLE_DIV);

    localparam logic [DW-1:0]    DIV_MAX = DW'(OVERSAMPLE_DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state, state_n;

    logic          s1, s2, rxs;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    sc;
    logic [2:0]    bc;
    logic [7:0]    shreg;

    logic          clr_div;
    logic          mid_start;
    logic          bit_end;
    logic          shift;
    logic          stop_ok;
    logic          stop_bad;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   cnt;
    logic               push, pop;
    logic               overrun_q;
    logic               fe_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= rs232_rx;
            s2 <= s1;
        end
    end

    assign rxs  = s2;
    assign tick = (div_cnt == DIV_MAX);

    // Restart the divider on the detected start edge so ticks stay centred.
    always_ff @(posedge clk) begin
        if (reset || clr_div) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (!rxs) state_n = S_START;
            end
            S_START: begin
                if (tick && sc == 4'd7) begin
                    state_n = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && sc == 4'hf && bc == 3'd7) begin
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && sc == 4'hf) begin
                    state_n = rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        clr_div   = (state == S_IDLE) && !rxs;
        mid_start = (state == S_START) && tick && (sc == 4'd7);
        bit_end   = tick && (sc == 4'hf);
        shift     = (state == S_DATA) && bit_end;
        stop_ok   = (state == S_STOP) && bit_end && rxs;
        stop_bad  = (state == S_STOP) && bit_end && !rxs;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sc    <= '0;
            bc    <= '0;
            shreg <= '0;
        end else begin
            if (state == S_IDLE) begin
                sc <= '0;
                bc <= '0;
            end else if (tick) begin
                if (mid_start || bit_end) begin
                    sc <= '0;
                end else begin
                    sc <= sc + 1'b1;
                end
            end
            if (shift) begin
                shreg <= {rxs, shreg[7:1]};
                bc    <= bc + 1'b1;
            end
        end
    end

    // A pop in the push cycle frees a slot even when the FIFO is full.
    assign pop  = rx.read_rx_data_ack && (cnt != '0);
    assign push = stop_ok && ((cnt != DEPTH_C) || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            if (stop_ok && !push) overrun_q <= 1'b1;
            fe_q <= stop_bad;
        end
    end

    assign rx.rx_data_out      = mem[rd_ptr];
    assign rx.rx_data_present  = (cnt != '0);
    assign rx.rx_buffer_full   = (cnt == DEPTH_C);
    assign rx.rx_overrun       = overrun_q;
    assign rx.rx_framing_error = fe_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard.
// DIV=4: one bit is 64 clocks, the stop sample lands 611 clocks after the start edge.
module tb_uart_rx_fifo;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;
    localparam int FRM = 10 * BIT;
    localparam int SMP = 611;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rs232_rx = 1'b1;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .OVERSAMPLE_DIV (DIV),
        .FIFO_AW        (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rs232_rx (rs232_rx),
        .rx       (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];
    logic ov_m = 1'b0;

    int fe_cycles = 0;
    int fe_pulses = 0;
    logic fe_d = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_framing_error) fe_cycles++;
        if (bus.rx_framing_error && !fe_d) fe_pulses++;
        fe_d = bus.rx_framing_error;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_present"}, bus.rx_data_present, 1'b0);
        chk({tag, "_full"}, bus.rx_buffer_full, 1'b0);
        chk({tag, "_overrun"}, bus.rx_overrun, 1'b0);
        chk({tag, "_ferr"}, bus.rx_framing_error, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        ov_m = 1'b0;
    endtask

    // One frame; optional ack and reset at a given clock index of the frame.
    task automatic send(input logic [7:0] d, input logic stop,
                        input int ack_at, input int rst_at,
                        output int rise, output int fe_at);
        logic [9:0] fr;
        logic exp_push;
        fr = {stop, d, 1'b0};
        exp_push = stop && (rst_at < 0) &&
                   ((q.size() < 16) || (ack_at >= 0));
        if (stop && rst_at < 0 && !exp_push) ov_m = 1'b1;
        rise = -1;
        fe_at = -1;
        for (int i = 0; i < FRM; i++) begin
            @(negedge clk);
            if (rise < 0 && bus.rx_data_present) rise = i;
            if (fe_at < 0 && bus.rx_framing_error) fe_at = i;
            if (rst_at >= 0 && i == rst_at + 1) chk_reset_vals("rst_mid");
            reset = (i == rst_at);
            if (i == ack_at) begin
                chk("ack_at_push_data", bus.rx_data_out, q.pop_front());
                bus.read_rx_data_ack = 1'b1;
            end else begin
                bus.read_rx_data_ack = 1'b0;
            end
            rs232_rx = fr[i / BIT];
        end
        @(negedge clk);
        reset = 1'b0;
        bus.read_rx_data_ack = 1'b0;
        if (rst_at >= 0) begin
            q.delete();
            ov_m = 1'b0;
        end
        if (exp_push) q.push_back(d);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("pop_present", bus.rx_data_present, 1'b1);
            chk("pop_data", bus.rx_data_out, q.pop_front());
            bus.read_rx_data_ack = 1'b1;
        end
        @(negedge clk);
        bus.read_rx_data_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int rise;
    int fe_at;
    int fe_base;

    initial begin
        bus.read_rx_data_ack = 1'b0;
        idle(5);
        reset = 1'b0;
        idle(2);
        chk_reset_vals("reset");

        send(8'hA5, 1'b1, -1, -1, rise, fe_at);
        chk("a5_rise", rise, SMP);
        chk("a5_no_ferr", fe_at, -1);
        chk("a5_overrun", bus.rx_overrun, 1'b0);
        pop_n(1);
        chk("a5_empty", bus.rx_data_present, 1'b0);

        for (int b = 0; b < 17; b++) begin
            send(8'(b), 1'b1, -1, -1, rise, fe_at);
            if (b == 14) chk("fill_not_full", bus.rx_buffer_full, 1'b0);
            if (b == 15) chk("fill_full", bus.rx_buffer_full, 1'b1);
            if (b == 15) chk("fill_no_ovr", bus.rx_overrun, 1'b0);
        end
        chk("ovr_set", bus.rx_overrun, ov_m);
        chk("ovr_full", bus.rx_buffer_full, 1'b1);
        pop_n(16);
        chk("ovr_sticky", bus.rx_overrun, 1'b1);
        chk("drain_empty", bus.rx_data_present, 1'b0);
        chk("drain_not_full", bus.rx_buffer_full, 1'b0);
        chk("ferr_none_yet", fe_pulses, 0);

        do_reset();
        idle(2);
        chk_reset_vals("reset2");
        for (int b = 0; b < 16; b++) begin
            send(8'(8'h20 + b), 1'b1, -1, -1, rise, fe_at);
        end
        chk("pp_full_before", bus.rx_buffer_full, 1'b1);
        send(8'h77, 1'b1, SMP - 1, -1, rise, fe_at);
        chk("pp_full_after", bus.rx_buffer_full, 1'b1);
        chk("pp_no_ovr", bus.rx_overrun, 1'b0);
        chk("pp_qsize", q.size(), 16);
        chk("pp_tail", q[15], 8'h77);
        pop_n(16);
        chk("pp_empty", bus.rx_data_present, 1'b0);

        fe_base = fe_pulses;
        send(8'h3C, 1'b0, -1, -1, rise, fe_at);
        chk("brk_fe_time", fe_at, SMP);
        rs232_rx = 1'b0;
        idle(3 * FRM);
        chk("brk_pulses", fe_pulses - fe_base, 1);
        chk("brk_width", fe_cycles, fe_pulses);
        chk("brk_no_push", bus.rx_data_present, 1'b0);
        rs232_rx = 1'b1;
        idle(100);
        send(8'h55, 1'b1, -1, -1, rise, fe_at);
        chk("after_brk_rise", rise, SMP);
        pop_n(1);

        fe_base = fe_pulses;
        rs232_rx = 1'b0;
        idle(5 * DIV);
        rs232_rx = 1'b1;
        idle(200);
        chk("glitch_no_push", bus.rx_data_present, 1'b0);
        chk("glitch_no_ferr", fe_pulses - fe_base, 0);
        send(8'h81, 1'b1, -1, -1, rise, fe_at);
        chk("glitch_next_rise", rise, SMP);
        pop_n(1);

        send(8'hFF, 1'b1, -1, 5 * BIT + BIT / 2, rise, fe_at);
        chk("rst_no_push", rise, -1);
        chk("rst_present", bus.rx_data_present, 1'b0);
        send(8'h12, 1'b1, -1, -1, rise, fe_at);
        chk("rst_next_rise", rise, SMP);
        pop_n(1);
        chk("end_empty", bus.rx_data_present, 1'b0);
        chk("end_ferr_total", fe_pulses, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
